// File: rtl/fact_pkg.sv
// Shared definitions for the factorial job scheduler: register map,
// STATUS layout, ID constant and scheduler state encoding.
package fact_pkg;

  localparam logic [1:0] ADDR_JOB    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_ID     = 2'd3;

  localparam int ST_JOBQ_EMPTY = 0;
  localparam int ST_JOBQ_FULL  = 1;
  localparam int ST_RESQ_EMPTY = 2;
  localparam int ST_RESQ_FULL  = 3;
  localparam int ST_OVF        = 4;
  localparam int ST_BUSY       = 5;
  localparam int ST_TMO        = 6;
  localparam int ST_COUNT_LSB  = 8;

  localparam int CTRL_IE    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLEAR = 2;

  localparam logic [31:0] ID_VALUE = 32'hFAC7_0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STORE
  } state_t;

  // An errored entry keeps only 31 result bits so bit 31 can carry the flag.
  function automatic logic [31:0] result_word(input logic [32:0] entry);
    return entry[32] ? {1'b1, entry[30:0]} : entry[31:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fact_sched.sv
// Memory-mapped scheduler: queues CPU jobs, runs them one at a time on the
// factorial engine via go/done, and queues results for the CPU to read.
module fact_sched
  import fact_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        fe_go,
  output logic [3:0]  fe_n,
  input  logic        fe_done,
  input  logic        fe_err,
  input  logic [31:0] fe_result,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_next;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          res_err;
  logic [31:0]   res_val;
  logic          ie, ovf, tmo;
  logic          job_wr, ctrl_wr, flush;
  logic          jobq_pop, jobq_full, jobq_empty;
  logic [3:0]    jobq_head;
  logic [AW:0]   jobq_count;
  logic          resq_push, resq_pop, resq_full, resq_empty;
  logic [32:0]   resq_head;
  logic [AW:0]   resq_count;
  logic [31:0]   status;
  logic          unused_bits;

  assign job_wr    = we && (a == ADDR_JOB);
  assign ctrl_wr   = we && (a == ADDR_STATUS);
  assign flush     = ctrl_wr && wd[CTRL_FLUSH];
  assign jobq_pop  = (state == S_LAUNCH);
  assign resq_push = (state == S_STORE) && !flush;
  assign resq_pop  = re && (a == ADDR_RESULT);
  assign fe_go     = (state == S_LAUNCH);
  assign tmo_hit   = (state == S_WAIT) && !fe_done && (tmo_cnt == TW'(TIMEOUT - 1));
  assign irq       = ie && !resq_empty;
  assign unused_bits = ^{wd[31:4], jobq_count};

  sync_fifo #(.WIDTH(4), .DEPTH(DEPTH)) u_jobq (
    .clk(clk), .rst(rst), .flush(flush),
    .push(job_wr), .pop(jobq_pop), .din(wd[3:0]),
    .dout(jobq_head), .full(jobq_full), .empty(jobq_empty), .count(jobq_count)
  );

  sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_resq (
    .clk(clk), .rst(rst), .flush(flush),
    .push(resq_push), .pop(resq_pop), .din({res_err, res_val}),
    .dout(resq_head), .full(resq_full), .empty(resq_empty), .count(resq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Only launch when a result slot is free; IDLE means nothing is in flight.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!jobq_empty && !resq_full) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT:   if (fe_done || tmo_hit) state_next = S_STORE;
      S_STORE:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_n    <= '0;
      tmo_cnt <= '0;
      res_err <= 1'b0;
      res_val <= '0;
    end else begin
      if (state == S_IDLE && state_next == S_LAUNCH) fe_n <= jobq_head;
      if (state == S_LAUNCH)    tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (state == S_WAIT && fe_done) begin
        res_err <= fe_err;
        res_val <= fe_result;
      end else if (tmo_hit) begin
        res_err <= 1'b1;
        res_val <= '0;
      end
    end
  end

  // A full job queue still takes a push in the cycle it is being popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie  <= 1'b0;
      ovf <= 1'b0;
      tmo <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ie <= wd[CTRL_IE];
        if (wd[CTRL_CLEAR]) begin
          ovf <= 1'b0;
          tmo <= 1'b0;
        end
      end
      if (job_wr && jobq_full && !jobq_pop) ovf <= 1'b1;
      if (tmo_hit) tmo <= 1'b1;
    end
  end

  always_comb begin
    status = '0;
    status[ST_JOBQ_EMPTY] = jobq_empty;
    status[ST_JOBQ_FULL]  = jobq_full;
    status[ST_RESQ_EMPTY] = resq_empty;
    status[ST_RESQ_FULL]  = resq_full;
    status[ST_OVF]        = ovf;
    status[ST_BUSY]       = (state != S_IDLE);
    status[ST_TMO]        = tmo;
    status[ST_COUNT_LSB +: 3] = 3'(resq_count);
  end

  always_comb begin
    rd = '0;
    case (a)
      ADDR_STATUS: rd = status;
      ADDR_RESULT: if (!resq_empty) rd = result_word(resq_head);
      ADDR_ID:     rd = ID_VALUE;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_sched.sv
// Self-checking bench for fact_sched: directed scenarios plus a randomized
// phase, with expected results from a factorial reference queue.
module tb_fact_sched;
  import fact_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  a;
  logic        we, re;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        fe_go;
  logic [3:0]  fe_n;
  logic        fe_done, fe_err;
  logic [31:0] fe_result;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Engine model state, written only by the engine process
  int         go_count = 0;
  int         go_cyc = 0;
  int         done_cyc = 0;
  logic [3:0] go_n = '0;

  // Engine controls, written only by the main sequence
  bit eng_stall = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  int inject_req = 0;

  logic [31:0] exp_q[$];

  fact_sched #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .a(a), .we(we), .re(re), .wd(wd), .rd(rd),
    .fe_go(fe_go), .fe_n(fe_n), .fe_done(fe_done), .fe_err(fe_err),
    .fe_result(fe_result), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] fact64(input int n);
    logic [63:0] f = 64'd1;
    for (int i = 2; i <= n; i++) f = f * 64'(i);
    return f;
  endfunction

  // What a RESULT read must return for a completed job with operand n
  function automatic logic [31:0] refRd(input int n);
    logic [63:0] f = fact64(n);
    if (n > 12) return {1'b1, f[30:0]};
    return f[31:0];
  endfunction

  // Factorial engine: answers after a random latency unless stalled;
  // an inject request produces a stray done pulse and drops any pending job.
  initial begin
    bit         pend = 1'b0;
    int         cnt = 0;
    logic [3:0] pend_n = '0;
    int         inject_ack = 0;
    logic [63:0] f;
    fe_done = 1'b0; fe_err = 1'b0; fe_result = '0;
    forever begin
      @(negedge clk);
      fe_done = 1'b0; fe_err = 1'b0; fe_result = '0;
      if (rst) begin
        pend = 1'b0;
      end else if (fe_go) begin
        go_count++;
        go_cyc = cyc;
        go_n = fe_n;
        pend = 1'b1;
        pend_n = fe_n;
        cnt = $urandom_range(lat_max, lat_min);
      end else if (inject_req != inject_ack) begin
        inject_ack = inject_req;
        pend = 1'b0;
        fe_done = 1'b1;
        fe_result = 32'd24;
        done_cyc = cyc;
      end else if (pend) begin
        if (cnt > 0) cnt--;
        else if (!eng_stall) begin
          f = fact64(int'(pend_n));
          fe_done = 1'b1;
          fe_err = (pend_n > 4'd12);
          fe_result = f[31:0];
          done_cyc = cyc;
          pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Bus write held across one rising edge; caller is at a falling edge
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    a = addr; wd = data; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic peek(input logic [1:0] addr, output logic [31:0] v);
    a = addr;
    #1 v = rd;
  endtask

  task automatic popResult(output logic [31:0] v);
    a = ADDR_RESULT; re = 1'b1;
    #1 v = rd;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitGo(input int gc, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      #1;
      if (go_count != gc) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("wait_go", 32'(ok), 32'd1);
  endtask

  task automatic waitStatusBit(input int bit_idx, input logic val, input int bound,
                               output bit ok, output int seen);
    logic [31:0] v;
    ok = 1'b0; seen = 0;
    for (int i = 0; i < bound; i++) begin
      peek(ADDR_STATUS, v);
      if (v[bit_idx] == val) begin ok = 1'b1; seen = cyc; break; end
      @(negedge clk);
    end
    checkOutput("wait_status", 32'(ok), 32'd1);
  endtask

  task automatic waitResult(input int bound, output bit ok, output int seen);
    waitStatusBit(ST_RESQ_EMPTY, 1'b0, bound, ok, seen);
  endtask

  task automatic drainAll(input string tag);
    logic [31:0] v, e;
    bit ok;
    int seen;
    while (exp_q.size() > 0) begin
      waitResult(200, ok, seen);
      if (!ok) break;
      popResult(v);
      e = exp_q.pop_front();
      checkOutput(tag, v, e);
    end
  endtask

  initial begin
    logic [31:0] v, e;
    bit ok;
    int seen, c0, gc, n;
    int jobs6[6] = '{3, 4, 5, 6, 7, 8};

    rst = 1'b1; a = '0; we = 1'b0; re = 1'b0; wd = '0;
    idle(2);
    rst = 1'b0;

    // Reset state
    peek(ADDR_STATUS, v); checkOutput("reset_status", v, 32'h0000_0005);
    peek(ADDR_ID, v);     checkOutput("id", v, ID_VALUE);
    peek(ADDR_RESULT, v); checkOutput("reset_result_empty", v, 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    idle(10);
    checkOutput("reset_no_go", 32'(go_count), 32'd0);

    // Single job: launch latency and result latency
    lat_min = 7; lat_max = 7;
    gc = go_count; c0 = cyc;
    exp_q.push_back(refRd(5));
    applyStimulus(ADDR_JOB, 32'd5);
    waitGo(gc, 20);
    checkOutput("go_latency", 32'(go_cyc - c0), 32'd2);
    checkOutput("go_operand", 32'(go_n), 32'd5);
    waitResult(50, ok, seen);
    checkOutput("result_latency", 32'(seen - done_cyc), 32'd2);
    peek(ADDR_STATUS, v); checkOutput("status_one_result", v, 32'h0000_0101);
    popResult(v); e = exp_q.pop_front(); checkOutput("result_5", v, e);
    checkOutput("result_5_value", v, 32'h0000_0078);
    peek(ADDR_STATUS, v); checkOutput("status_after_pop", v, 32'h0000_0005);

    // Overflow: engine holds job 1 while 6 more jobs arrive
    eng_stall = 1'b1;
    gc = go_count;
    exp_q.push_back(refRd(1));
    applyStimulus(ADDR_JOB, 32'd1);
    waitGo(gc, 20);
    foreach (jobs6[i]) begin
      if (i < 4) exp_q.push_back(refRd(jobs6[i]));
      applyStimulus(ADDR_JOB, 32'(jobs6[i]));
    end
    peek(ADDR_STATUS, v); checkOutput("status_overflow", v, 32'h0000_0036);
    lat_min = 1; lat_max = 5;
    eng_stall = 1'b0;
    drainAll("ovf_result_order");
    applyStimulus(ADDR_STATUS, 32'h4);
    peek(ADDR_STATUS, v); checkOutput("status_ovf_cleared", v, 32'h0000_0005);

    // Timeout on a stalled engine, then the next job proceeds
    eng_stall = 1'b1;
    gc = go_count;
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(refRd(3));
    applyStimulus(ADDR_JOB, 32'd2);
    applyStimulus(ADDR_JOB, 32'd3);
    waitGo(gc, 20);
    c0 = go_cyc;
    while (cyc < c0 + 250) @(negedge clk);
    peek(ADDR_STATUS, v); checkOutput("status_waiting", v, 32'h0000_0024);
    waitResult(30, ok, seen);
    // 255 WAIT cycles, one STORE cycle, then visible
    checkOutput("timeout_latency", 32'(seen - c0), 32'd257);
    peek(ADDR_STATUS, v); checkOutput("status_tmo_flag", 32'(v[ST_TMO]), 32'd1);
    popResult(v); e = exp_q.pop_front(); checkOutput("timeout_result", v, e);
    eng_stall = 1'b0;
    drainAll("after_timeout_result");
    applyStimulus(ADDR_STATUS, 32'h4);
    peek(ADDR_STATUS, v); checkOutput("status_tmo_cleared", v, 32'h0000_0005);

    // Backpressure: full result queue blocks launches until a pop
    lat_min = 1; lat_max = 4;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(refRd(i));
      applyStimulus(ADDR_JOB, 32'(i));
    end
    waitStatusBit(ST_RESQ_FULL, 1'b1, 200, ok, seen);
    gc = go_count;
    exp_q.push_back(refRd(5));
    exp_q.push_back(refRd(6));
    applyStimulus(ADDR_JOB, 32'd5);
    applyStimulus(ADDR_JOB, 32'd6);
    idle(20);
    checkOutput("bp_no_launch", 32'(go_count), 32'(gc));
    peek(ADDR_STATUS, v); checkOutput("bp_status", v, 32'h0000_0408);
    popResult(v); e = exp_q.pop_front(); checkOutput("bp_first_result", v, e);
    waitStatusBit(ST_RESQ_FULL, 1'b1, 100, ok, seen);
    idle(20);
    checkOutput("bp_one_launch", 32'(go_count), 32'(gc + 1));
    checkOutput("bp_launch_operand", 32'(go_n), 32'd5);
    peek(ADDR_STATUS, v); checkOutput("bp_status_again", v, 32'h0000_0408);
    drainAll("bp_result_order");

    // Flush during WAIT, then a stray done must be ignored
    eng_stall = 1'b1;
    gc = go_count;
    applyStimulus(ADDR_JOB, 32'd4);
    waitGo(gc, 20);
    idle(3);
    applyStimulus(ADDR_STATUS, 32'h2);
    inject_req++;
    idle(5);
    peek(ADDR_STATUS, v); checkOutput("flush_status", v, 32'h0000_0005);
    peek(ADDR_RESULT, v); checkOutput("flush_no_result", v, 32'h0);
    checkOutput("flush_no_relaunch", 32'(go_count), 32'(gc + 1));

    // Interrupt rises the cycle after STORE
    eng_stall = 1'b0;
    lat_min = 3; lat_max = 3;
    applyStimulus(ADDR_STATUS, 32'h1);
    exp_q.push_back(refRd(3));
    applyStimulus(ADDR_JOB, 32'd3);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (irq) begin ok = 1'b1; seen = cyc; break; end
      @(negedge clk);
    end
    checkOutput("irq_seen", 32'(ok), 32'd1);
    checkOutput("irq_latency", 32'(seen - done_cyc), 32'd2);
    popResult(v); e = exp_q.pop_front(); checkOutput("irq_result", v, e);
    #1 checkOutput("irq_cleared", 32'(irq), 32'd0);

    // Randomized traffic against the reference queue
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          peek(ADDR_STATUS, v);
          if (!v[ST_JOBQ_FULL]) begin
            n = $urandom_range(0, 15);
            exp_q.push_back(refRd(n));
            applyStimulus(ADDR_JOB, 32'(n));
          end else idle(1);
        end
        1: begin
          peek(ADDR_STATUS, v);
          if (!v[ST_RESQ_EMPTY]) begin
            popResult(v);
            e = exp_q.pop_front();
            checkOutput("rand_result", v, e);
          end else idle(1);
        end
        default: idle(1);
      endcase
    end
    drainAll("rand_drain");
    checkOutput("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a job, followed by a stray done
    eng_stall = 1'b1;
    gc = go_count;
    applyStimulus(ADDR_JOB, 32'd7);
    waitGo(gc, 20);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    inject_req++;
    idle(10);
    peek(ADDR_STATUS, v); checkOutput("midjob_reset_status", v, 32'h0000_0005);
    checkOutput("midjob_reset_irq", 32'(irq), 32'd0);
    checkOutput("midjob_no_relaunch", 32'(go_count), 32'(gc + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fact_sched.md
Name: fact_sched

Overview:
- Memory-mapped job scheduler that sequences the factorial engine on behalf of the CPU.
- The CPU pushes operands into a job queue. The scheduler launches each job on the engine with a go/done handshake and captures results into a result queue. The CPU reads results back.
- Sits in the 0x0900 decode slot of the system address decoder, alongside the GPIO block. The decoder drives we/re; the read mux selects rd.

Parameters:
DEPTH, 4, entries in both the job queue and the result queue (power of 2, ≥2)
TIMEOUT, 255, max cycles in WAIT before the job is aborted with error

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
a  in  2  word address (alu_out[3:2])
we  in  1  bus write strobe, qualified by decoder
re  in  1  bus read strobe, qualified by decoder; pops result on a=2
wd  in  32  bus write data
rd  out  32  bus read data, combinational from a
fe_go  out  1  engine start, one-cycle pulse
fe_n  out  4  engine operand, held stable from LAUNCH to done
fe_done  in  1  engine completion, one-cycle pulse
fe_err  in  1  engine overflow flag, valid with fe_done
fe_result  in  32  engine result, valid with fe_done
irq  out  1  level interrupt: result queue non-empty and IE=1

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Both queues empty; FSM enters IDLE.
  - fe_go=0, fe_n=0, irq=0, IE=0, sticky flags cleared.
  - rd reflects reset state (STATUS reads 0x0000_0005).
- Register map:
  - a=0 JOB (write): push wd[3:0] into the job queue. Job queue full → drop, set OVF sticky (STATUS[4]).
  - a=1 STATUS (read): [0] jobq_empty, [1] jobq_full, [2] resq_empty, [3] resq_full, [4] OVF, [5] busy (FSM≠IDLE), [6] TMO sticky, [10:8] result count, others 0.
  - a=1 CTRL (write): [0] IE, [1] flush (self-clearing), [2] clear OVF/TMO.
  - a=2 RESULT (read): rd = {err, resq_head[30:0]} when err=1, else the full 32-bit result. re pops the entry. Empty → rd=0, no pop, no state change.
  - a=3 ID (read): constant 0xFAC7_0001; writes ignored.
- FSM:
  - IDLE: job queue non-empty AND result queue has ≥1 free slot (counting the in-flight job) → LAUNCH.
  - LAUNCH (1 cycle): pop job, load fe_n, fe_go=1, clear timeout counter → WAIT.
  - WAIT: fe_done=1 → STORE with result/err latched. Counter reaches TIMEOUT → STORE with err=1, result=0, TMO sticky set.
  - STORE (1 cycle): push {err,result} into the result queue → IDLE.
- Latency: JOB write at cycle t → fe_go at t+2 if idle. Result visible at STATUS/RESULT 2 cycles after fe_done.
- Backpressure: no launch while the result queue cannot absorb the result, so the result queue never overflows.
- Simultaneous events:
  - JOB push and internal pop in the same cycle: both take effect; count is unchanged; a full queue accepts the push.
  - RESULT pop and STORE push in the same cycle: both take effect.
- Flush:
  - Empties both queues.
  - In WAIT or LAUNCH: FSM → IDLE; a subsequent fe_done is ignored.
  - In STORE: the push is suppressed.
- fe_done outside WAIT is ignored.
- Reset mid-job: engine state is not the scheduler's concern. Scheduler returns to IDLE and ignores a stray fe_done.
- Queue pointers are log2(DEPTH)+1 bits with natural wrap. Full/empty come from the MSB compare.

Decomposition:
- Shared package fact_pkg:
  - register offsets JOB/STATUS/RESULT/ID
  - STATUS bit indices
  - ID constant
  - FSM state encoding (IDLE, LAUNCH, WAIT, STORE)
- One sub-module: sync_fifo (width, depth parameters; push/pop/full/empty/count; simultaneous push/pop on full allowed). Instantiated twice: 4-bit jobs, 33-bit results.

Test Plan:
- Reset, then read STATUS and ID → 0x0000_0005 and 0xFAC7_0001. irq=0, fe_go never pulses.
- Write JOB=5, engine model answers 120 after 7 cycles → fe_go at t+2 with fe_n=5. RESULT read returns 0x78. STATUS[2] returns to 1 after the pop.
- Write 6 jobs (3,4,5,6,7,8) while the engine stalls → fourth... only 4 accepted, OVF=1. Results read in order 6,24,120,720. CTRL[2] clears OVF.
- Hold fe_done low → after 255 WAIT cycles, RESULT=0x8000_0000 (err), TMO=1, next job launches.
- Fill the result queue (4 results unread) with 2 jobs pending → no fe_go until one RESULT pop, then exactly one launch.
- Flush during WAIT, then pulse fe_done → queues empty, busy=0, no result pushed. Set IE=1 with new job → irq rises the cycle after STORE.
